aes_job_sequencer: RTL and testbench
====================================

# aes_job_sequencer

Job-queue front end that sits directly upstream of the AES-CTR stream engine, between the host softreg port and the engine's softreg port. The host stages a key, source address, destination address and word count, then pushes them as one job. The sequencer programs the engine with a fixed softreg write sequence and polls the engine's remaining-word count until it reaches zero. It then retires the job and starts the next one, so the host can queue several encryptions back to back.

## Interface
- LOG_JOBS, 2: log2 of job queue depth.
- ID_CREDITS, 8: value written to engine input-read credit register 0x38.
- OM_CREDITS, 8: value written to engine write-address credit register 0x40.
- POLL_GAP, 16: idle cycles between a nonzero poll response and the next poll (≥1).
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- host_req_valid  in  1  host softreg request strobe
- host_req_isWrite  in  1  1 = write
- host_req_addr  in  32  host register address
- host_req_data  in  64  host write data
- host_resp_valid  out  1  host read response strobe
- host_resp_data  out  64  host read data (status word)
- eng_req_valid  out  1  engine softreg request strobe
- eng_req_isWrite  out  1  engine request is write
- eng_req_addr  out  32  engine register address
- eng_req_data  out  64  engine write data
- eng_resp_valid  in  1  engine read response strobe
- eng_resp_data  in  64  engine remaining output words

## Operation
- Host writes:
  - 0x00/0x08/0x10/0x18 stage key[63:0]..key[255:192].
  - 0x20 stages src.
  - 0x28 stages dst.
  - 0x30 pushes {staged key, src, dst, data as words} into the job queue.
  - 0x48 clears done_count and overflow.
  - Other write addresses are ignored.
- Push while queue full: job dropped, sticky overflow set.
- Host read at any address returns status:
  - [0] busy (FSM not IDLE)
  - [1] overflow
  - [15:8] queue occupancy
  - [63:32] done_count
  - all other bits 0.
- FSM states:
  - IDLE: queue nonempty → LOAD, index 0.
  - LOAD: one engine write per cycle, in this order: key 0x00, 0x08, 0x10, 0x18; 0x20 src; 0x28 dst; 0x38 ID_CREDITS; 0x40 OM_CREDITS; 0x30 words. The 0x30 write is always last because it starts the engine. After 0x30 → POLL.
  - POLL: issue one read (eng_req_isWrite=0, addr 0x00) → WAIT.
  - WAIT: on eng_resp_valid, data==0 → DONE; nonzero → GAP.
  - GAP: count POLL_GAP cycles → POLL.
  - DONE: pop queue, done_count+1 (wraps at 2^32) → IDLE.
- A words=0 job is still programmed and retires on its first poll.
- eng_req_* are zero whenever eng_req_valid=0.

## Timing
- Reset values:
  - All outputs 0.
  - FSM IDLE; queue empty.
  - done_count 0; overflow 0.
  - Staged registers 0.
  - Key cache invalid.
- Host read: host_resp_valid pulses exactly one cycle after the request; data is sampled at request cycle.
- Engine writes in LOAD are on consecutive cycles, with no bubbles:
  - 9 cycles without key cache.
  - 5 cycles on a key-cache hit.
- Engine response is expected one cycle after the poll. WAIT holds indefinitely with no timeout.
- Push and pop in the same cycle: occupancy unchanged; the pushed job is accepted even if the queue was full before the pop.
- A push in the same cycle as a 0x48 write: both take effect.
- rst mid-job: immediate return to IDLE, queue flushed, no further engine requests. The engine shares rst.

## Configuration
- AES_SEQ_KEY_CACHE_EN defined:
  - The sequencer holds the last programmed key and a valid bit (cleared by reset).
  - If the job key equals the cached valid key, the four key writes are skipped and LOAD starts at 0x20.
- Undefined: all four key writes are always issued.

## Structure
- Shared package holds:
  - Host register address constants (0x00–0x48).
  - Engine register address constants (0x00–0x40).
  - Status bit positions.
  - Job struct typedef: key 256, src 64, dst 64, words 64 (448 bits).
  - FSM state enum.
- Job queue is the existing HullFIFO: TYPE 0, WIDTH 448, LOG_DEPTH LOG_JOBS. Occupancy is tracked locally.

## Test plan
- Single job: key=0x1..4 per word, src 0x1000, dst 0x8000, words 100.
  - Expect 9 ordered engine writes, 0x30 last with data 100.
  - Stub replies 64, then 0.
  - Expect 2 polls spaced ≥POLL_GAP+1 cycles apart, then done_count=1 and busy=0.
- Push 2^LOG_JOBS+1 jobs with the engine stalled (poll returns nonzero).
  - Expect occupancy 4 and overflow=1.
  - A 0x48 write clears overflow.
- Two jobs with identical keys and AES_SEQ_KEY_CACHE_EN defined.
  - Expect the second LOAD to be 5 writes starting at 0x20.
  - Without the macro, both LOADs are 9 writes.
- Assert rst at the 4th LOAD cycle.
  - Expect eng_req_valid=0 the next cycle, status=0, and no further engine requests.
- words=0 job: programs 0x30 with 0; stub replies 0; retires after 1 poll.
- Host read during LOAD: resp one cycle later with busy=1 and correct occupancy.

Source files
------------

// File: rtl/aes_job_sequencer_pkg.sv
// Shared definitions for the AES-CTR job sequencer: register maps, status layout,
// job record and sequencer FSM states.
package aes_job_sequencer_pkg;

    // Host-side register map
    localparam logic [31:0] HOST_KEY0  = 32'h00;
    localparam logic [31:0] HOST_KEY1  = 32'h08;
    localparam logic [31:0] HOST_KEY2  = 32'h10;
    localparam logic [31:0] HOST_KEY3  = 32'h18;
    localparam logic [31:0] HOST_SRC   = 32'h20;
    localparam logic [31:0] HOST_DST   = 32'h28;
    localparam logic [31:0] HOST_PUSH  = 32'h30;
    localparam logic [31:0] HOST_CLEAR = 32'h48;

    // Engine-side register map
    localparam logic [31:0] ENG_KEY0    = 32'h00;
    localparam logic [31:0] ENG_KEY1    = 32'h08;
    localparam logic [31:0] ENG_KEY2    = 32'h10;
    localparam logic [31:0] ENG_KEY3    = 32'h18;
    localparam logic [31:0] ENG_SRC     = 32'h20;
    localparam logic [31:0] ENG_DST     = 32'h28;
    localparam logic [31:0] ENG_WORDS   = 32'h30;
    localparam logic [31:0] ENG_ID_CRED = 32'h38;
    localparam logic [31:0] ENG_OM_CRED = 32'h40;
    localparam logic [31:0] ENG_POLL    = 32'h00;

    localparam int ST_BUSY     = 0;
    localparam int ST_OVERFLOW = 1;
    localparam int ST_OCC_LO   = 8;
    localparam int ST_DONE_LO  = 32;

    // LOAD step indices: 0..3 key words, 4 src, 5 dst, 6/7 credits, 8 word count
    localparam logic [3:0] LOAD_SRC  = 4'd4;
    localparam logic [3:0] LOAD_LAST = 4'd8;

    typedef struct packed {
        logic [3:0][63:0] key;
        logic [63:0]      src;
        logic [63:0]      dst;
        logic [63:0]      words;
    } job_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_POLL,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    function automatic logic [31:0] load_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    return ENG_KEY0;
            4'd1:    return ENG_KEY1;
            4'd2:    return ENG_KEY2;
            4'd3:    return ENG_KEY3;
            4'd4:    return ENG_SRC;
            4'd5:    return ENG_DST;
            4'd6:    return ENG_ID_CRED;
            4'd7:    return ENG_OM_CRED;
            default: return ENG_WORDS;
        endcase
    endfunction

endpackage

// File: rtl/HullFIFO.sv
// Generic FIFO used for job queues. TYPE 0 is show-ahead (q is the head entry);
// any other TYPE registers q on rdreq. A write while full is accepted if a read happens.
module HullFIFO #(
    parameter int TYPE      = 0,
    parameter int WIDTH     = 32,
    parameter int LOG_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wrreq,
    input  logic [WIDTH-1:0] data,
    output logic             full,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    input  logic             rdreq
);
    logic [WIDTH-1:0]   mem [2**LOG_DEPTH];
    logic [LOG_DEPTH:0] wr_ptr, rd_ptr;
    logic               do_wr, do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]) &&
                   (wr_ptr[LOG_DEPTH-1:0] == rd_ptr[LOG_DEPTH-1:0]);
    assign do_rd = rdreq && !empty;
    assign do_wr = wrreq && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[LOG_DEPTH-1:0]] <= data;
    end

    generate
        if (TYPE == 0) begin : g_showahead
            assign q = mem[rd_ptr[LOG_DEPTH-1:0]];
        end else begin : g_registered
            always_ff @(posedge clk) begin
                if (rst)        q <= '0;
                else if (do_rd) q <= mem[rd_ptr[LOG_DEPTH-1:0]];
            end
        end
    endgenerate

endmodule

// File: rtl/aes_job_sequencer.sv
// Host job queue in front of the AES-CTR engine: programs each job, polls until done.
// Optional key cache (skips key writes on repeat key) enabled by AES_SEQ_KEY_CACHE_EN.
module aes_job_sequencer #(
    parameter int LOG_JOBS   = 2,
    parameter int ID_CREDITS = 8,
    parameter int OM_CREDITS = 8,
    parameter int POLL_GAP   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_req_valid,
    input  logic        host_req_isWrite,
    input  logic [31:0] host_req_addr,
    input  logic [63:0] host_req_data,
    output logic        host_resp_valid,
    output logic [63:0] host_resp_data,
    output logic        eng_req_valid,
    output logic        eng_req_isWrite,
    output logic [31:0] eng_req_addr,
    output logic [63:0] eng_req_data,
    input  logic        eng_resp_valid,
    input  logic [63:0] eng_resp_data
);
    import aes_job_sequencer_pkg::*;

    localparam int GAP_W = $clog2(POLL_GAP + 1);

    logic [3:0][63:0]  key_stage;
    logic [63:0]       src_stage, dst_stage;
    logic [LOG_JOBS:0] occ;
    logic              overflow;
    logic [31:0]       done_count;
    logic [63:0]       status;

    state_t            state, state_nx;
    logic [3:0]        idx, idx_nx;
    logic [GAP_W-1:0]  gap_cnt, gap_nx;

    job_t              push_job, head;
    logic              fifo_full, fifo_empty;
    logic              host_wr, push, clear, pop, accept, key_hit;

    assign host_wr = host_req_valid && host_req_isWrite;
    assign push    = host_wr && (host_req_addr == HOST_PUSH);
    assign clear   = host_wr && (host_req_addr == HOST_CLEAR);
    assign pop     = (state == S_DONE);
    // A pop frees a slot in the same cycle, so a push into a full queue still lands
    assign accept  = push && (!fifo_full || pop);

    always_comb begin
        push_job       = '0;
        push_job.key   = key_stage;
        push_job.src   = src_stage;
        push_job.dst   = dst_stage;
        push_job.words = host_req_data;
    end

    HullFIFO #(
        .TYPE      (0),
        .WIDTH     ($bits(job_t)),
        .LOG_DEPTH (LOG_JOBS)
    ) u_jobs (
        .clk   (clk),
        .rst   (rst),
        .wrreq (accept),
        .data  (push_job),
        .full  (fifo_full),
        .q     (head),
        .empty (fifo_empty),
        .rdreq (pop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            key_stage <= '0;
            src_stage <= '0;
            dst_stage <= '0;
        end else if (host_wr) begin
            case (host_req_addr)
                HOST_KEY0: key_stage[0] <= host_req_data;
                HOST_KEY1: key_stage[1] <= host_req_data;
                HOST_KEY2: key_stage[2] <= host_req_data;
                HOST_KEY3: key_stage[3] <= host_req_data;
                HOST_SRC:  src_stage    <= host_req_data;
                HOST_DST:  dst_stage    <= host_req_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ        <= '0;
            overflow   <= 1'b0;
            done_count <= '0;
        end else begin
            if (accept && !pop)      occ <= occ + 1'b1;
            else if (!accept && pop) occ <= occ - 1'b1;
            if (push && !accept) overflow <= 1'b1;
            else if (clear)      overflow <= 1'b0;
            done_count <= (clear ? 32'd0 : done_count) + {31'd0, pop};
        end
    end

    always_comb begin
        status                      = '0;
        status[ST_BUSY]             = (state != S_IDLE);
        status[ST_OVERFLOW]         = overflow;
        status[ST_OCC_LO +: 8]      = 8'(occ);
        status[ST_DONE_LO +: 32]    = done_count;
    end

    // Status is captured in the request cycle and returned one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            host_resp_valid <= 1'b0;
            host_resp_data  <= '0;
        end else begin
            host_resp_valid <= host_req_valid && !host_req_isWrite;
            host_resp_data  <= (host_req_valid && !host_req_isWrite) ? status : 64'd0;
        end
    end

`ifdef AES_SEQ_KEY_CACHE_EN
    logic [3:0][63:0] cache_key;
    logic             cache_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_key   <= '0;
            cache_valid <= 1'b0;
        end else if (state == S_IDLE && !fifo_empty) begin
            cache_key   <= head.key;
            cache_valid <= 1'b1;
        end
    end

    assign key_hit = cache_valid && (cache_key == head.key);
`else
    assign key_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            gap_cnt <= gap_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        idx_nx          = idx;
        gap_nx          = gap_cnt;
        eng_req_valid   = 1'b0;
        eng_req_isWrite = 1'b0;
        eng_req_addr    = '0;
        eng_req_data    = '0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_nx = S_LOAD;
                    idx_nx   = key_hit ? LOAD_SRC : 4'd0;
                end
            end
            S_LOAD: begin
                eng_req_valid   = 1'b1;
                eng_req_isWrite = 1'b1;
                eng_req_addr    = load_addr(idx);
                case (idx)
                    4'd0, 4'd1, 4'd2, 4'd3: eng_req_data = head.key[idx[1:0]];
                    4'd4:    eng_req_data = head.src;
                    4'd5:    eng_req_data = head.dst;
                    4'd6:    eng_req_data = 64'(ID_CREDITS);
                    4'd7:    eng_req_data = 64'(OM_CREDITS);
                    default: eng_req_data = head.words;
                endcase
                if (idx == LOAD_LAST) state_nx = S_POLL;
                else                  idx_nx   = idx + 1'b1;
            end
            S_POLL: begin
                eng_req_valid = 1'b1;
                eng_req_addr  = ENG_POLL;
                state_nx      = S_WAIT;
            end
            S_WAIT: begin
                if (eng_resp_valid) begin
                    state_nx = (eng_resp_data == 64'd0) ? S_DONE : S_GAP;
                    gap_nx   = '0;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(POLL_GAP - 1)) state_nx = S_POLL;
                else                                 gap_nx   = gap_cnt + 1'b1;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_job_sequencer.sv
// Self-checking bench for aes_job_sequencer: engine stub + queue-based reference of
// the expected engine write stream, derived from the job list and key-cache rules.
module tb_aes_job_sequencer;
    localparam int POLL_GAP = 16;
    localparam int ID_CRED  = 8;
    localparam int OM_CRED  = 8;

    logic        clk = 0, rst = 1;
    logic        host_req_valid = 0, host_req_isWrite = 0;
    logic [31:0] host_req_addr = 0;
    logic [63:0] host_req_data = 0;
    logic        host_resp_valid;
    logic [63:0] host_resp_data;
    logic        eng_req_valid, eng_req_isWrite;
    logic [31:0] eng_req_addr;
    logic [63:0] eng_req_data;
    logic        eng_resp_valid = 0;
    logic [63:0] eng_resp_data = 0;

    aes_job_sequencer #(
        .LOG_JOBS(2), .ID_CREDITS(ID_CRED), .OM_CREDITS(OM_CRED), .POLL_GAP(POLL_GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .host_req_valid(host_req_valid), .host_req_isWrite(host_req_isWrite),
        .host_req_addr(host_req_addr), .host_req_data(host_req_data),
        .host_resp_valid(host_resp_valid), .host_resp_data(host_resp_data),
        .eng_req_valid(eng_req_valid), .eng_req_isWrite(eng_req_isWrite),
        .eng_req_addr(eng_req_addr), .eng_req_data(eng_req_data),
        .eng_resp_valid(eng_resp_valid), .eng_resp_data(eng_resp_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [95:0] wr_q[$], exp_q[$];
    int          wr_cyc[$], poll_q[$];
    logic [63:0] resp_q[$];
    logic [63:0] dflt = 0;
    bit          pend = 0;

    bit          m_kv = 0;
    logic [255:0] m_key = 0;
    int          m_done = 0;
    int          checks = 0, errors = 0;

    // Engine stub and monitor: answers each poll one cycle later
    always @(negedge clk) begin
        eng_resp_valid = pend;
        if (pend) eng_resp_data = (resp_q.size() > 0) ? resp_q.pop_front() : dflt;
        else      eng_resp_data = 0;
        pend = eng_req_valid && !eng_req_isWrite && !rst;
        if (eng_req_valid) begin
            if (eng_req_isWrite) begin
                wr_q.push_back({eng_req_addr, eng_req_data});
                wr_cyc.push_back(cyc);
            end else poll_q.push_back(cyc);
        end
    end

    function automatic logic [63:0] exp_status(bit busy, bit ovf, int occ, int done);
        return {32'(done), 16'd0, 8'(occ), 6'd0, ovf, busy};
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[i*32 +: 32] = $urandom;
        return k;
    endfunction

    // Reference: writes the engine must see for one job, in order
    task automatic model_job(input logic [255:0] k, input logic [63:0] s, d, w);
        bit hit = 0;
`ifdef AES_SEQ_KEY_CACHE_EN
        hit = m_kv && (m_key == k);
`endif
        if (!hit) for (int i = 0; i < 4; i++) exp_q.push_back({32'(i * 8), k[i*64 +: 64]});
        exp_q.push_back({32'h20, s});
        exp_q.push_back({32'h28, d});
        exp_q.push_back({32'h38, 64'(ID_CRED)});
        exp_q.push_back({32'h40, 64'(OM_CRED)});
        exp_q.push_back({32'h30, w});
        m_kv  = 1;
        m_key = k;
    endtask

    task automatic clear_q();
        wr_q.delete(); exp_q.delete(); wr_cyc.delete(); poll_q.delete(); resp_q.delete();
    endtask

    task automatic host_write(input logic [31:0] a, input logic [63:0] d);
        @(negedge clk);
        host_req_valid = 1; host_req_isWrite = 1; host_req_addr = a; host_req_data = d;
        @(negedge clk);
        host_req_valid = 0; host_req_isWrite = 0; host_req_addr = 0; host_req_data = 0;
    endtask

    task automatic host_read(output bit rv, output logic [63:0] rd);
        @(negedge clk);
        host_req_valid = 1; host_req_isWrite = 0; host_req_addr = $urandom;
        @(negedge clk);
        host_req_valid = 0; host_req_addr = 0;
        rv = host_resp_valid;
        rd = host_resp_data;
    endtask

    task automatic push_job(input logic [255:0] k, input logic [63:0] s, d, w, input bit model_it);
        for (int i = 0; i < 4; i++) host_write(32'(i * 8), k[i*64 +: 64]);
        host_write(32'h20, s);
        host_write(32'h28, d);
        host_write(32'h30, w);
        if (model_it) model_job(k, s, d, w);
    endtask

    task automatic wait_done(input int n, input string name);
        bit rv; logic [63:0] rd; bit ok = 0;
        rd = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            host_read(rv, rd);
            if (rv && rd[63:32] == n[31:0] && !rd[0]) ok = 1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL %s timeout: status %h, want done_count %0d idle", name, rd, n); end
    endtask

    task automatic test_reset();
        bit rv; logic [63:0] rd;
        rst = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({eng_req_valid, eng_req_isWrite, eng_req_addr, eng_req_data, host_resp_valid, host_resp_data} !== '0) begin
            errors++; $display("FAIL reset_outputs: eng_valid=%b addr=%h resp_valid=%b, want all 0", eng_req_valid, eng_req_addr, host_resp_valid);
        end
        rst = 0;
        host_read(rv, rd);
        checks++;
        if (rv !== 1'b1 || rd !== 64'd0) begin errors++; $display("FAIL reset_status: valid=%b data=%h, want 1/0", rv, rd); end
    endtask

    task automatic test_single();
        bit rv; logic [63:0] rd; logic [95:0] last;
        clear_q();
        resp_q.push_back(64); resp_q.push_back(0);
        push_job({64'd4, 64'd3, 64'd2, 64'd1}, 64'h1000, 64'h8000, 64'd100, 1'b1);
        wait_done(1, "single_done"); m_done = 1;
        checks++;
        if (wr_q.size() != 9) begin errors++; $display("FAIL single_nwr: got %0d writes, want 9", wr_q.size()); end
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_wr%0d: got %h, want %h", i, wr_q[i], exp_q[i]); end
        end
        for (int i = 1; i < wr_cyc.size(); i++) begin
            checks++;
            if (wr_cyc[i] != wr_cyc[0] + i) begin errors++; $display("FAIL single_bubble%0d: cycle %0d, want %0d", i, wr_cyc[i], wr_cyc[0] + i); end
        end
        last = (wr_q.size() > 0) ? wr_q[wr_q.size() - 1] : '0;
        checks++;
        if (last !== {32'h30, 64'd100}) begin errors++; $display("FAIL single_last: got %h, want addr 30 data 100", last); end
        checks++;
        if (poll_q.size() != 2) begin errors++; $display("FAIL single_npoll: got %0d, want 2", poll_q.size()); end
        else begin
            checks++;
            if (poll_q[1] - poll_q[0] < POLL_GAP + 1) begin
                errors++; $display("FAIL single_gap: polls %0d apart, want >= %0d", poll_q[1] - poll_q[0], POLL_GAP + 1);
            end
        end
        host_read(rv, rd);
        checks++;
        if (rv !== 1'b1 || rd !== exp_status(0, 0, 0, 1)) begin errors++; $display("FAIL single_status: got %h, want %h", rd, exp_status(0, 0, 0, 1)); end
    endtask

    task automatic test_words_zero();
        logic [95:0] last;
        clear_q();
        resp_q.push_back(0);
        push_job(rand_key(), {$urandom, $urandom}, {$urandom, $urandom}, 64'd0, 1'b1);
        wait_done(m_done + 1, "wz_done"); m_done++;
        for (int i = 0; i < wr_q.size() || i < exp_q.size(); i++) begin
            checks++;
            if (i >= wr_q.size() || i >= exp_q.size() || wr_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL wz_wr%0d: got %0d writes, want %0d (mismatch at %0d)", i, wr_q.size(), exp_q.size(), i);
            end
        end
        last = (wr_q.size() > 0) ? wr_q[wr_q.size() - 1] : '1;
        checks++;
        if (last !== {32'h30, 64'd0}) begin errors++; $display("FAIL wz_last: got %h, want addr 30 data 0", last); end
        checks++;
        if (poll_q.size() != 1) begin errors++; $display("FAIL wz_npoll: got %0d, want 1", poll_q.size()); end
    endtask

    task automatic test_key_cache();
        logic [255:0] k; int exp_n; logic [31:0] exp_a2; logic [95:0] second;
        k = rand_key();
        if (k == m_key) k[0] = ~k[0];
`ifdef AES_SEQ_KEY_CACHE_EN
        exp_n = 14; exp_a2 = 32'h20;
`else
        exp_n = 18; exp_a2 = 32'h00;
`endif
        clear_q();
        push_job(k, {$urandom, $urandom}, {$urandom, $urandom}, 64'($urandom_range(1, 50)), 1'b1);
        push_job(k, {$urandom, $urandom}, {$urandom, $urandom}, 64'($urandom_range(1, 50)), 1'b1);
        wait_done(m_done + 2, "kc_done"); m_done += 2;
        checks++;
        if (wr_q.size() != exp_n) begin errors++; $display("FAIL kc_nwr: got %0d writes, want %0d", wr_q.size(), exp_n); end
        second = (wr_q.size() > 9) ? wr_q[9] : '1;
        checks++;
        if (second[95:64] !== exp_a2) begin errors++; $display("FAIL kc_first_addr: got %h, want %h", second[95:64], exp_a2); end
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL kc_wr%0d: got %h, want %h", i, wr_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_host_read_load();
        bit found = 0; bit rv; logic [63:0] rd;
        clear_q();
        push_job(rand_key(), {$urandom, $urandom}, {$urandom, $urandom}, 64'd7, 1'b1);
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (eng_req_valid && eng_req_isWrite) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL hrl_load: no LOAD seen, want LOAD within 50 cycles"); end
        host_req_valid = 1; host_req_isWrite = 0; host_req_addr = $urandom;
        @(negedge clk);
        host_req_valid = 0; host_req_addr = 0;
        rv = host_resp_valid; rd = host_resp_data;
        checks++;
        if (rv !== 1'b1 || rd !== exp_status(1, 0, 1, m_done)) begin
            errors++; $display("FAIL hrl_status: valid=%b data=%h, want 1/%h", rv, rd, exp_status(1, 0, 1, m_done));
        end
        wait_done(m_done + 1, "hrl_done"); m_done++;
    endtask

    task automatic test_overflow();
        logic [255:0] pool[2]; bit rv; logic [63:0] rd; int nr;
        pool[0] = rand_key(); pool[1] = rand_key();
        clear_q();
        dflt = 64'd1;
        for (int j = 0; j < 5; j++)
            push_job(pool[$urandom_range(0, 1)], {$urandom, $urandom}, {$urandom, $urandom},
                     64'($urandom_range(0, 200)), (j < 4));
        host_read(rv, rd);
        checks++;
        if (rv !== 1'b1 || rd !== exp_status(1, 1, 4, m_done)) begin errors++; $display("FAIL ovf_status: got %h, want %h", rd, exp_status(1, 1, 4, m_done)); end
        host_write(32'h48, {$urandom, $urandom}); m_done = 0;
        host_read(rv, rd);
        checks++;
        if (rv !== 1'b1 || rd !== exp_status(1, 0, 4, 0)) begin errors++; $display("FAIL ovf_clear: got %h, want %h", rd, exp_status(1, 0, 4, 0)); end
        nr = $urandom_range(0, 3);
        for (int r = 0; r < nr; r++) resp_q.push_back(64'($urandom_range(1, 99)));
        dflt = 0;
        wait_done(4, "ovf_drain"); m_done = 4;
        checks++;
        if (wr_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_nwr: got %0d writes, want %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_wr%0d: got %h, want %h", i, wr_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid(output logic [255:0] k);
        int n = 0; bit found = 0; bit rv; logic [63:0] rd;
        k = rand_key();
        if (k == m_key) k[0] = ~k[0];
        clear_q();
        push_job(k, {$urandom, $urandom}, {$urandom, $urandom}, 64'd33, 1'b0);
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (eng_req_valid && eng_req_isWrite) n++;
            if (n == 4) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rm_load: saw %0d LOAD writes, want 4", n); end
        rst = 1;
        @(negedge clk);
        checks++;
        if ({eng_req_valid, eng_req_isWrite, eng_req_addr, eng_req_data} !== '0) begin
            errors++; $display("FAIL rm_eng_idle: valid=%b addr=%h, want 0", eng_req_valid, eng_req_addr);
        end
        repeat (2) @(negedge clk);
        rst = 0; m_kv = 0; m_done = 0;
        host_read(rv, rd);
        checks++;
        if (rv !== 1'b1 || rd !== 64'd0) begin errors++; $display("FAIL rm_status: got %h, want 0", rd); end
        repeat (40) @(negedge clk);
        checks++;
        if (wr_q.size() != 4 || poll_q.size() != 0) begin
            errors++; $display("FAIL rm_quiet: got %0d writes %0d polls, want 4 and 0", wr_q.size(), poll_q.size());
        end
    endtask

    task automatic test_after_reset(input logic [255:0] k);
        clear_q();
        push_job(k, {$urandom, $urandom}, {$urandom, $urandom}, 64'd5, 1'b1);
        wait_done(1, "ar_done"); m_done = 1;
        checks++;
        if (wr_q.size() != 9) begin errors++; $display("FAIL ar_nwr: got %0d writes, want 9", wr_q.size()); end
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL ar_wr%0d: got %h, want %h", i, wr_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        logic [255:0] k;
        test_reset();
        test_single();
        test_words_zero();
        test_key_cache();
        test_host_read_load();
        test_overflow();
        test_reset_mid(k);
        test_after_reset(k);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded 50000 cycles");
        $fatal(1, "timeout");
    end

endmodule
